aes_ctr_ctrl: RTL
=================

// Module: aes_ctr_ctrl
// PURPOSE
//   Sequences one aes_core instance for AES-128 CTR mode, for payload encryption ahead of the OFDM mapper.
//   Loads the key into the core once per job and issues counter blocks IV[127:32] || (IV[31:0]+i).
//   Buffers the returned keystream and XORs it with the plaintext stream.
//   Produces a ciphertext stream with valid/ready flow control.
// PARAMETERS
//   KS_DEPTH   2    keystream buffer entries; bounds in-flight + buffered blocks (>=1)
//   LEN_W      16   width of the job length in 128-bit blocks
// PORTS
//   clk            in   1       single clock, all logic posedge
//   rst_n          in   1       asynchronous, active-low reset
//   start          in   1       one-cycle job start; sampled only in IDLE
//   key            in   128     AES-128 key, sampled on start
//   iv             in   128     initial counter block, sampled on start
//   num_blocks     in   LEN_W   job length in blocks, sampled on start; 0 = empty job
//   busy           out  1       high from accepted start until done
//   done           out  1       one-cycle pulse when the job ends
//   ctr_wrap_err   out  1       sticky per job; low 32 counter bits wrapped
//   pt_valid       in   1       plaintext block valid
//   pt_ready       out  1       plaintext accepted when pt_valid & pt_ready
//   pt_data        in   128     plaintext block
//   ct_valid       out  1       ciphertext valid
//   ct_ready       in   1       downstream ready
//   ct_data        out  128     pt_data ^ keystream head
//   core_key_ready in   1       from aes_core.key_ready
//   core_key_valid out  1       to aes_core.key_valid
//   core_main_key  out  128     to aes_core.main_key
//   core_data_ready in  1       from aes_core.data_ready
//   core_data_valid out 1       to aes_core.data_valid
//   core_data_in   out  128     to aes_core.data_in (counter block)
//   core_out_valid in   1       from aes_core.data_out_valid
//   core_out       in   128     from aes_core.data_out
// BEHAVIOUR
//   Reset (rst_n low, async): state IDLE, all outputs 0, buffer empty, counters 0, error cleared.
//   FSM states:
//   - IDLE -> LOAD_KEY on start. num_blocks==0: stay IDLE, pulse done next cycle, busy stays 0.
//   - LOAD_KEY: wait for core_key_ready. Then drive core_key_valid=1 and core_main_key=key for exactly one
//     registered cycle -> RUN. core_main_key is 0 whenever core_key_valid is 0.
//   - RUN, issue side: issued_cnt < num_blocks and (outstanding + buf_count) < KS_DEPTH and core_data_ready
//     -> next cycle core_data_valid=1 for one cycle, core_data_in = {iv[127:32], ctr}.
//     Then ctr <= ctr+1 (mod 2^32) and outstanding++. At most one issue per cycle.
//   - RUN, counter wrap: if the issued ctr was 32'hFFFFFFFF, set ctr_wrap_err (sticky until next start).
//     Issuing continues; the wrapped counter is used as-is.
//   - RUN, return side: core_out_valid pushes core_out into the FIFO and decrements outstanding.
//     It never overflows (guaranteed by the issue rule). core_out_valid in IDLE/LOAD_KEY is ignored.
//   - RUN, output side (combinational join):
//     - ct_valid = pt_valid & !buf_empty
//     - pt_ready = ct_ready & !buf_empty
//     - ct_data  = pt_data ^ buf_head
//     - On a transfer, pop the FIFO and increment done_cnt.
//   - RUN -> IDLE when done_cnt reaches num_blocks. done pulses the cycle after the last transfer; busy drops with it.
//   - Same-cycle push and pop: FIFO count unchanged, data order preserved.
//   - Issue and return in the same cycle: outstanding unchanged.
//   - Latency: first ct_valid = core latency + 1 cycle after the first issue, given pt_valid is already high.
//   - start while busy is ignored; key, iv and num_blocks are held internally for the whole job.
// TESTING
//   1. Reset mid-RUN (2 blocks in flight) -> all outputs 0 in the same cycle; restart yields correct ciphertext.
//   2. SP800-38A F.5.1 CTR vectors:
//      - key 2b7e151628aed2a6abf7158809cf4f3c, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, num_blocks 2
//      - pt 6bc1bee22e409f96e93d7e117393172a -> ct 874d6191b620e3261bef6864990db6ce
//      - pt ae2d8a571e03ac9c9eb76fac45af8e51 -> ct 9806f66b7970fdff8617187bb9fffdff
//      - expect one done pulse, ctr_wrap_err 0.
//   3. Backpressure: ct_ready low 20 cycles, 4-block job -> exactly KS_DEPTH core issues, no loss, in-order ct.
//   4. Wrap: iv low word FFFFFFFF, 2 blocks -> second core_data_in low word 00000000; ctr_wrap_err=1 until next start.
//   5. num_blocks=0 -> no core_key_valid, done pulse, busy 0.
//      start during RUN -> ignored, job unchanged.
//   6. pt_valid gapped randomly, 16 blocks -> ct matches software model; core_key_valid pulsed exactly once.

Source files
------------

// File: rtl/aes_ctr_ctrl.sv
// rtl/aes_ctr_ctrl.sv - AES-128 CTR-mode sequencer around one external aes_core
// Loads the key, issues counter blocks, buffers keystream and XORs it onto the plaintext stream.
module aes_ctr_ctrl #(
  parameter int KS_DEPTH = 2,
  parameter int LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [127:0]     key,
  input  logic [127:0]     iv,
  input  logic [LEN_W-1:0] num_blocks,
  output logic             busy,
  output logic             done,
  output logic             ctr_wrap_err,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [127:0]     pt_data,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic [127:0]     ct_data,
  input  logic             core_key_ready,
  output logic             core_key_valid,
  output logic [127:0]     core_main_key,
  input  logic             core_data_ready,
  output logic             core_data_valid,
  output logic [127:0]     core_data_in,
  input  logic             core_out_valid,
  input  logic [127:0]     core_out
);

  localparam int PW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int CW = $clog2(KS_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_KEY, S_RUN} state_t;

  state_t           r_state;
  logic [127:0]     r_key;
  logic [95:0]      r_iv_hi;
  logic [31:0]      r_ctr;
  logic [LEN_W-1:0] r_num;
  logic [LEN_W-1:0] r_issued;
  logic [LEN_W-1:0] r_done_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_wrap_err;
  logic             r_core_key_valid;
  logic [127:0]     r_core_main_key;
  logic             r_core_data_valid;
  logic [127:0]     r_core_data_in;
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [127:0]     r_mem [KS_DEPTH];

  logic w_run;
  logic w_buf_empty;
  logic w_xfer;
  logic w_push;
  logic w_issue;
  logic [CW:0] w_in_use;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(KS_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_run       = (r_state == S_RUN);
  assign w_buf_empty = (r_count == '0);
  assign w_in_use    = {1'b0, r_outstanding} + {1'b0, r_count};
  // Blocks in flight plus buffered never exceed the buffer, so returns cannot overflow it
  assign w_issue     = w_run && (r_issued < r_num) && (w_in_use < (CW+1)'(KS_DEPTH)) && core_data_ready;
  assign w_push      = w_run && core_out_valid;

  assign ct_valid = w_run & pt_valid & ~w_buf_empty;
  assign pt_ready = w_run & ct_ready & ~w_buf_empty;
  assign ct_data  = (w_run && !w_buf_empty) ? (pt_data ^ r_mem[r_rd_ptr]) : '0;
  assign w_xfer   = ct_valid & ct_ready;

  assign busy            = r_busy;
  assign done            = r_done;
  assign ctr_wrap_err    = r_wrap_err;
  assign core_key_valid  = r_core_key_valid;
  assign core_main_key   = r_core_main_key;
  assign core_data_valid = r_core_data_valid;
  assign core_data_in    = r_core_data_in;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= core_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_xfer) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_xfer})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case ({w_issue, w_push})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_key             <= '0;
      r_iv_hi           <= '0;
      r_ctr             <= '0;
      r_num             <= '0;
      r_issued          <= '0;
      r_done_cnt        <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_wrap_err        <= 1'b0;
      r_core_key_valid  <= 1'b0;
      r_core_main_key   <= '0;
      r_core_data_valid <= 1'b0;
      r_core_data_in    <= '0;
    end else begin
      r_done            <= 1'b0;
      r_core_key_valid  <= 1'b0;
      r_core_main_key   <= '0;
      r_core_data_valid <= 1'b0;
      r_core_data_in    <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key      <= key;
            r_iv_hi    <= iv[127:32];
            r_ctr      <= iv[31:0];
            r_num      <= num_blocks;
            r_issued   <= '0;
            r_done_cnt <= '0;
            r_wrap_err <= 1'b0;
            if (num_blocks == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_LOAD_KEY;
            end
          end
        end
        S_LOAD_KEY: begin
          if (core_key_ready) begin
            r_core_key_valid <= 1'b1;
            r_core_main_key  <= r_key;
            r_state          <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_core_data_valid <= 1'b1;
            r_core_data_in    <= {r_iv_hi, r_ctr};
            r_ctr             <= r_ctr + 32'd1;
            r_issued          <= r_issued + LEN_W'(1);
            if (r_ctr == 32'hFFFF_FFFF) r_wrap_err <= 1'b1;
          end
          if (w_xfer) begin
            r_done_cnt <= r_done_cnt + LEN_W'(1);
            if (r_done_cnt + LEN_W'(1) == r_num) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
